// File: rtl/bilstm_fifo_pkg.sv
// bilstm_fifo_pkg: shared types and constants for the BiLSTM FIFO read path
package bilstm_fifo_pkg;
  typedef enum logic {RD_IDLE, RD_RUN} rd_state_t;
  localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/stream_skid_buf2.sv
// stream_skid_buf2: 2-entry register FIFO, head always in slot 0
module stream_skid_buf2 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] head_o,
  output logic [1:0]        cnt_o
);
  logic [DATA_W-1:0] m0_q, m0_d, m1_q, m1_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              slot;
  always_comb begin
    slot  = (cnt_q - {1'b0, pop_i}) != 2'd0;
    cnt_d = cnt_q + {1'b0, wr_i} - {1'b0, pop_i};
    m0_d  = (wr_i && !slot) ? data_i : pop_i ? m1_q : m0_q;
    m1_d  = (wr_i && slot) ? data_i : m1_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      m0_q  <= '0;
      m1_q  <= '0;
      cnt_q <= '0;
    end else begin
      m0_q  <= m0_d;
      m1_q  <= m1_d;
      cnt_q <= cnt_d;
    end
  assign head_o = m0_q;
  assign cnt_o  = cnt_q;
endmodule

// File: rtl/fifo_vector_reader.sv
// fifo_vector_reader: drains NUM_VEC x VEC_LEN words from the FIFO into an indexed valid/ready stream
module fifo_vector_reader
  import bilstm_fifo_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int VEC_LEN = 8,
  parameter  int CNT_W   = 16,
  localparam int IW      = VEC_LEN > 1 ? $clog2(VEC_LEN) : 1,
  localparam int TW      = CNT_W + $clog2(VEC_LEN) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [CNT_W-1:0]         num_vec_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     fifo_rd_en_o,
  input  logic                     fifo_empty_i,
  input  logic signed [DATA_W-1:0] fifo_data_i,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic signed [DATA_W-1:0] m_data_o,
  output logic                     m_last_o,
  output logic [IW-1:0]            m_word_idx_o,
  output logic [CNT_W-1:0]         m_vec_idx_o
);
  rd_state_t        state_q;
  logic [TW-1:0]    total_q, req_cnt_q, pop_cnt_q;
  logic             inflight_q, done_q;
  logic [IW-1:0]    widx_q;
  logic [CNT_W-1:0] vidx_q;
  logic [1:0]       buf_cnt;
  logic [2:0]       credit;
  logic             pop, last_pop, rd_en, go;
  always_comb begin
    pop      = m_valid_o && m_ready_i;
    last_pop = pop && (pop_cnt_q == total_q - TW'(1));
    go       = state_q == RD_IDLE && start_i;
    // words already held or in flight after this cycle's pop must leave a free slot
    credit   = 3'(buf_cnt) + 3'(inflight_q) - 3'(pop);
    rd_en    = state_q == RD_RUN && !fifo_empty_i && req_cnt_q < total_q && credit < 3'(SKID_DEPTH);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= RD_IDLE;
      total_q    <= '0;
      req_cnt_q  <= '0;
      pop_cnt_q  <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      widx_q     <= '0;
      vidx_q     <= '0;
    end else begin
      inflight_q <= rd_en;
      done_q     <= go && num_vec_i == '0;
      if (rd_en) req_cnt_q <= req_cnt_q + TW'(1);
      if (pop) begin
        pop_cnt_q <= pop_cnt_q + TW'(1);
        widx_q    <= m_last_o ? '0 : widx_q + IW'(1);
        vidx_q    <= vidx_q + CNT_W'(m_last_o);
      end
      if (go && num_vec_i != '0) begin
        state_q   <= RD_RUN;
        total_q   <= TW'(num_vec_i) * TW'(VEC_LEN);
        req_cnt_q <= '0;
        pop_cnt_q <= '0;
        widx_q    <= '0;
        vidx_q    <= '0;
      end else if (last_pop) state_q <= RD_IDLE;
    end
  stream_skid_buf2 #(.DATA_W(DATA_W)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .wr_i  (inflight_q),
    .pop_i (pop),
    .data_i(fifo_data_i),
    .head_o(m_data_o),
    .cnt_o (buf_cnt)
  );
  assign m_valid_o    = buf_cnt != 2'd0;
  assign busy_o       = state_q == RD_RUN;
  assign done_o       = done_q | last_pop;
  assign fifo_rd_en_o = rd_en;
  assign m_last_o     = widx_q == IW'(VEC_LEN - 1);
  assign m_word_idx_o = widx_q;
  assign m_vec_idx_o  = vidx_q;
endmodule

// File: tb/tb_fifo_vector_reader.sv
// tb_fifo_vector_reader: directed vectors plus scoreboarded bursts against a FIFO model
module tb_fifo_vector_reader;
  localparam int DW = 32;
  localparam int VL = 8;
  localparam int CW = 16;
  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start_i;
  logic [CW-1:0]        num_vec_i;
  logic                 busy_o, done_o, fifo_rd_en_o, fifo_empty_i;
  logic signed [DW-1:0] fifo_data_i, m_data_o;
  logic                 m_valid_o, m_ready_i, m_last_o;
  logic [2:0]           m_word_idx_o;
  logic [CW-1:0]        m_vec_idx_o;
  int checks = 0, failures = 0;
  logic [DW-1:0] mem [0:255];
  int wr_ptr = 0, rd_ptr = 0, underflow = 0, next_val = 1;
  typedef struct {
    logic        start;
    logic        ready;
    logic        busy;
    logic        rd;
    logic        valid;
    logic        done;
    logic        last;
    logic [31:0] data;
    int          widx;
    int          vidx;
  } vec_t;
  vec_t tbl [20];
  fifo_vector_reader #(.DATA_W(DW), .VEC_LEN(VL), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .num_vec_i   (num_vec_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .fifo_rd_en_o(fifo_rd_en_o),
    .fifo_empty_i(fifo_empty_i),
    .fifo_data_i (fifo_data_i),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_data_o    (m_data_o),
    .m_last_o    (m_last_o),
    .m_word_idx_o(m_word_idx_o),
    .m_vec_idx_o (m_vec_idx_o)
  );
  always #5 clk = ~clk;
  // FIFO model: registered read data, counts reads attempted while empty
  assign fifo_empty_i = (wr_ptr == rd_ptr);
  always @(posedge clk)
    if (fifo_rd_en_o) begin
      if (wr_ptr == rd_ptr) underflow <= underflow + 1;
      else begin
        fifo_data_i <= mem[rd_ptr];
        rd_ptr      <= rd_ptr + 1;
      end
    end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = next_val;
      wr_ptr++;
      next_val++;
    end
  endtask
  task automatic check_reset(input string nm);
    chk({nm, " busy"}, busy_o, 0);
    chk({nm, " done"}, done_o, 0);
    chk({nm, " rd_en"}, fifo_rd_en_o, 0);
    chk({nm, " valid"}, m_valid_o, 0);
    chk({nm, " data"}, m_data_o, 0);
    chk({nm, " last"}, m_last_o, 0);
    chk({nm, " widx"}, m_word_idx_o, 0);
    chk({nm, " vidx"}, m_vec_idx_o, 0);
  endtask
  // entered and left 1 time unit after a rising edge; returns mid-cycle on abort
  task automatic run_burst(input string nm, input int nvec, input int mode, input int late_cyc,
                           input int late_n, input int abort_at, input int restart_cyc);
    int base, exp_n, pops, reads, dones, gap;
    logic stalled, pop, pl;
    logic [31:0] pd;
    logic [2:0] pw;
    logic [15:0] pv;
    base = rd_ptr; exp_n = nvec * VL;
    pops = 0; reads = 0; dones = 0; gap = 0; stalled = 0;
    pd = '0; pl = 0; pw = '0; pv = '0;
    for (int cyc = 0; cyc < 300 && pops < exp_n; cyc++) begin
      start_i   = (cyc == 0) || (cyc == restart_cyc);
      num_vec_i = CW'(cyc == 0 ? nvec : nvec + 3);
      m_ready_i = (mode == 0) || (cyc % 2 == 0);
      if (cyc == late_cyc) push(late_n);
      @(negedge clk);
      pop = m_valid_o && m_ready_i;
      if (fifo_rd_en_o) chk({nm, " credit"}, (reads - pops - int'(pop)) < 2, 1);
      if (stalled) begin
        chk({nm, " stall_valid"}, m_valid_o, 1);
        chk({nm, " stall_data"}, m_data_o, pd);
        chk({nm, " stall_last"}, m_last_o, pl);
        chk({nm, " stall_widx"}, m_word_idx_o, pw);
        chk({nm, " stall_vidx"}, m_vec_idx_o, pv);
      end
      if (pop) begin
        chk({nm, " data"}, m_data_o, mem[base + pops]);
        chk({nm, " widx"}, m_word_idx_o, pops % VL);
        chk({nm, " vidx"}, m_vec_idx_o, pops / VL);
        chk({nm, " last"}, m_last_o, (pops % VL) == VL - 1);
        chk({nm, " done"}, done_o, pops == exp_n - 1);
      end else chk({nm, " done_idle"}, done_o, 0);
      if (!m_valid_o && pops == 3 && late_n > 0) gap = 1;
      stalled = m_valid_o && !m_ready_i;
      pd = m_data_o; pl = m_last_o; pw = m_word_idx_o; pv = m_vec_idx_o;
      reads += int'(fifo_rd_en_o);
      pops  += int'(pop);
      dones += int'(done_o);
      if (abort_at > 0 && pops == abort_at) begin
        start_i = 0;
        return;
      end
      @(posedge clk); #1;
    end
    start_i = 0;
    chk({nm, " words"}, pops, exp_n);
    chk({nm, " dones"}, dones, 1);
    chk({nm, " underflow"}, underflow, 0);
    if (late_n > 0) chk({nm, " gap"}, gap, 1);
    @(negedge clk);
    chk({nm, " end_busy"}, busy_o, 0);
    chk({nm, " end_done"}, done_o, 0);
    chk({nm, " end_rd"}, fifo_rd_en_o, 0);
    @(posedge clk); #1;
  endtask
  initial begin
    rst = 1; start_i = 0; num_vec_i = '0; m_ready_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;
    rst = 0;
    push(16);
    for (int c = 0; c < 20; c++) begin
      tbl[c].start = c == 0;
      tbl[c].ready = 1;
      tbl[c].busy  = c >= 1 && c <= 18;
      tbl[c].rd    = c >= 1 && c <= 16;
      tbl[c].valid = c >= 3 && c <= 18;
      tbl[c].done  = c == 18;
      tbl[c].data  = 32'(c - 2);
      tbl[c].last  = ((c - 3) % 8) == 7;
      tbl[c].widx  = (c - 3) % 8;
      tbl[c].vidx  = (c - 3) / 8;
    end
    for (int c = 0; c < 20; c++) begin
      start_i   = tbl[c].start;
      num_vec_i = CW'(2);
      m_ready_i = tbl[c].ready;
      @(negedge clk);
      chk($sformatf("tbl%0d busy", c), busy_o, tbl[c].busy);
      chk($sformatf("tbl%0d rd_en", c), fifo_rd_en_o, tbl[c].rd);
      chk($sformatf("tbl%0d valid", c), m_valid_o, tbl[c].valid);
      chk($sformatf("tbl%0d done", c), done_o, tbl[c].done);
      if (tbl[c].valid) begin
        chk($sformatf("tbl%0d data", c), m_data_o, tbl[c].data);
        chk($sformatf("tbl%0d last", c), m_last_o, tbl[c].last);
        chk($sformatf("tbl%0d widx", c), m_word_idx_o, tbl[c].widx);
        chk($sformatf("tbl%0d vidx", c), m_vec_idx_o, tbl[c].vidx);
      end
      @(posedge clk); #1;
    end
    start_i = 0;
    push(16);
    run_burst("toggle", 2, 1, -1, 0, 0, -1);
    start_i = 1; num_vec_i = '0;
    @(negedge clk);
    chk("zero busy0", busy_o, 0);
    chk("zero done0", done_o, 0);
    @(posedge clk); #1;
    start_i = 0;
    @(negedge clk);
    chk("zero done1", done_o, 1);
    chk("zero busy1", busy_o, 0);
    chk("zero rd1", fifo_rd_en_o, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero done2", done_o, 0);
    chk("zero rd2", fifo_rd_en_o, 0);
    @(posedge clk); #1;
    push(3);
    run_burst("empty", 1, 0, 10, 5, 0, -1);
    push(16);
    run_burst("busy_start", 2, 1, -1, 0, 0, 5);
    push(16);
    run_burst("abort", 2, 0, -1, 0, 5, -1);
    #2 rst = 1;
    #1 check_reset("midrst");
    @(posedge clk); #1;
    rst = 0;
    run_burst("restart", 1, 0, -1, 0, 0, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
